// File: rtl/imm_gen_pipe_pkg.sv
// Shared definitions for the immediate-generation pipeline.
//   - ImmSrc encodings (3-bit immediate format select)
//   - entry_t: one buffered result {valid, imm, tag, err}
//   - is_reserved(): true for the reserved format select
// entry_t is sized for the widest legal configuration (64-bit immediate,
// up to 16-bit tag). Narrower instances use the low bits only.
package imm_gen_pipe_pkg;

    localparam logic [2:0] IMM_I   = 3'b000;
    localparam logic [2:0] IMM_S   = 3'b001;
    localparam logic [2:0] IMM_B   = 3'b010;
    localparam logic [2:0] IMM_J   = 3'b011;
    localparam logic [2:0] IMM_U   = 3'b100;
    localparam logic [2:0] IMM_Z   = 3'b101;
    localparam logic [2:0] IMM_SH  = 3'b110;
    localparam logic [2:0] IMM_RSV = 3'b111;

    localparam int IMM_MAX_W = 64;
    localparam int TAG_MAX_W = 16;

    typedef struct packed {
        logic                 valid;
        logic [IMM_MAX_W-1:0] imm;
        logic [TAG_MAX_W-1:0] tag;
        logic                 err;
    } entry_t;

    localparam entry_t ENTRY_EMPTY = '0;

    function automatic logic is_reserved(input logic [2:0] immsrc);
        return (immsrc == IMM_RSV);
    endfunction

endpackage

// File: rtl/imm_gen_pipe_imm_extend.sv
// imm_extend: combinational immediate decode.
// Ports:
//   i_instr  [31:7]  instruction bits carrying immediate fields
//   i_immsrc [2:0]   format select (see imm_gen_pipe_pkg)
//   o_imm    [XLEN]  extended immediate
//   o_err            reserved format selected
// Every format is first assembled as a 64-bit value and then truncated to
// XLEN, so the 32- and 64-bit variants share one decode table and U-type
// automatically sign-extends above bit 31 when XLEN=64.
module imm_extend
    import imm_gen_pipe_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:7]     i_instr,
    input  logic [2:0]      i_immsrc,
    output logic [XLEN-1:0] o_imm,
    output logic            o_err
);

    logic [63:0] w_imm_wide;
    logic        w_sign;
    logic        w_unused_wide;

    assign w_sign = i_instr[31];

    // Format decode into a 64-bit immediate
    always_comb begin
        w_imm_wide = 64'h0;
        case (i_immsrc)
            IMM_I:  w_imm_wide = {{52{w_sign}}, i_instr[31:20]};
            IMM_S:  w_imm_wide = {{52{w_sign}}, i_instr[31:25], i_instr[11:7]};
            IMM_B:  w_imm_wide = {{51{w_sign}}, i_instr[31], i_instr[7],
                                  i_instr[30:25], i_instr[11:8], 1'b0};
            IMM_J:  w_imm_wide = {{43{w_sign}}, i_instr[31], i_instr[19:12],
                                  i_instr[20], i_instr[30:21], 1'b0};
            IMM_U:  w_imm_wide = {{32{w_sign}}, i_instr[31:12], 12'h000};
            IMM_Z:  w_imm_wide = {59'h0, i_instr[19:15]};
            IMM_SH: begin
                // RV64 shift amounts use one extra bit (instr[25])
                if (XLEN == 64) begin
                    w_imm_wide = {58'h0, i_instr[25:20]};
                end else begin
                    w_imm_wide = {59'h0, i_instr[24:20]};
                end
            end
            IMM_RSV: w_imm_wide = 64'h0;
            default: w_imm_wide = 64'h0;
        endcase
    end

    assign o_imm = w_imm_wide[XLEN-1:0];
    assign o_err = is_reserved(i_immsrc);

    // Upper bits are intentionally dropped when XLEN=32
    assign w_unused_wide = ^w_imm_wide;

endmodule

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: immediate generator with a 2-entry skid buffer.
// Ports:
//   clk, rst_n (sync, active-low), flush
//   in_valid/in_ready/in_instr/in_immsrc/in_tag   upstream handshake + data
//   out_valid/out_ready/out_imm/out_tag/out_err   downstream handshake + data
// The immediate is decoded combinationally at the input and registered.
// Main register M drives the outputs; skid register S absorbs one entry
// when M is stalled. in_ready is a register equal to "S will be empty".
// TAG_W must not exceed imm_gen_pipe_pkg::TAG_MAX_W.
module imm_gen_pipe
    import imm_gen_pipe_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [2:0]       in_immsrc,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_err
);

    logic [XLEN-1:0] w_imm;
    logic            w_err;
    logic            w_acc;
    logic            w_fire;
    entry_t          w_new;
    entry_t          w_m_nxt;
    entry_t          w_s_nxt;
    entry_t          r_m;
    entry_t          r_s;
    logic            r_in_ready;
    logic            w_unused_opcode;
    logic            w_unused_entry;

    imm_extend #(
        .XLEN(XLEN)
    ) u_imm_extend (
        .i_instr (in_instr[31:7]),
        .i_immsrc(in_immsrc),
        .o_imm   (w_imm),
        .o_err   (w_err)
    );

    assign w_acc  = in_valid && r_in_ready;
    assign w_fire = r_m.valid && out_ready;

    // Pack the freshly decoded instruction into an entry
    always_comb begin
        w_new       = ENTRY_EMPTY;
        w_new.valid = 1'b1;
        w_new.imm   = IMM_MAX_W'(w_imm);
        w_new.tag   = TAG_MAX_W'(in_tag);
        w_new.err   = w_err;
    end

    // Skid-buffer next state: S refills M first, then new data goes to
    // whichever register is free. S is only written while M is stalled.
    always_comb begin
        w_m_nxt = r_m;
        w_s_nxt = r_s;
        if (w_fire) begin
            if (r_s.valid) begin
                // in_ready is low here, so no accept can collide
                w_m_nxt       = r_s;
                w_s_nxt.valid = 1'b0;
            end else if (w_acc) begin
                w_m_nxt = w_new;
            end else begin
                w_m_nxt.valid = 1'b0;
            end
        end else if (!r_m.valid) begin
            if (w_acc) begin
                w_m_nxt = w_new;
            end else begin
                w_m_nxt = r_m;
            end
        end else begin
            if (w_acc) begin
                w_s_nxt = w_new;
            end else begin
                w_s_nxt = r_s;
            end
        end
    end

    // State registers: reset beats flush beats normal handshaking
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_m        <= ENTRY_EMPTY;
            r_s        <= ENTRY_EMPTY;
            r_in_ready <= 1'b1;
        end else if (flush) begin
            r_m.valid  <= 1'b0;
            r_s.valid  <= 1'b0;
            r_in_ready <= 1'b1;
        end else begin
            r_m        <= w_m_nxt;
            r_s        <= w_s_nxt;
            r_in_ready <= !w_s_nxt.valid;
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_m.valid;
    assign out_imm   = r_m.imm[XLEN-1:0];
    assign out_tag   = r_m.tag[TAG_W-1:0];
    assign out_err   = r_m.err;

    // Opcode bits and the unused upper entry bits carry no immediate data
    assign w_unused_opcode = ^in_instr[6:0];
    assign w_unused_entry  = ^{r_m.imm, r_m.tag};

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Self-checking bench for imm_gen_pipe (XLEN=32 scoreboard instance plus
// an XLEN=64 instance for the 64-bit decode cases).
module tb_imm_gen_pipe;

    localparam int TAG_W = 5;

    logic             clk = 1'b0;
    logic             rst_n, flush;
    logic             in_valid, in_ready, out_valid, out_ready, out_err;
    logic [31:0]      in_instr, out_imm;
    logic [2:0]       in_immsrc;
    logic [TAG_W-1:0] in_tag, out_tag;

    logic             b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_err;
    logic [31:0]      b_in_instr;
    logic [63:0]      b_out_imm;
    logic [2:0]       b_in_immsrc;
    logic [TAG_W-1:0] b_in_tag, b_out_tag;

    typedef struct packed {
        logic [31:0]      imm;
        logic [TAG_W-1:0] tag;
        logic             err;
    } exp_t;

    exp_t sb[$];
    int   nerr = 0;
    int   nchk = 0;

    // Directed 32-bit vectors with hand-computed results
    logic [31:0] d_instr [8] = '{32'hFFF00093, 32'hFE000EE3, 32'h12345037, 32'hFFFFFFFF,
                                 32'h03F0D093, 32'hFFDFF0EF, 32'h000FD073, 32'hFE112E23};
    logic [2:0]  d_src   [8] = '{3'd0, 3'd2, 3'd4, 3'd7, 3'd6, 3'd3, 3'd5, 3'd1};
    logic [31:0] d_imm   [8] = '{32'hFFFFFFFF, 32'hFFFFFFFC, 32'h12345000, 32'h00000000,
                                 32'h0000001F, 32'hFFFFFFFC, 32'h0000001F, 32'hFFFFFFFC};
    logic        d_err   [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

    always #5 clk = ~clk;

    imm_gen_pipe #(.XLEN(32), .TAG_W(TAG_W)) dut32 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
        .in_immsrc(in_immsrc), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_imm(out_imm),
        .out_tag(out_tag), .out_err(out_err)
    );

    imm_gen_pipe #(.XLEN(64), .TAG_W(TAG_W)) dut64 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_instr(b_in_instr),
        .in_immsrc(b_in_immsrc), .in_tag(b_in_tag),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_imm(b_out_imm),
        .out_tag(b_out_tag), .out_err(b_out_err)
    );

    // Reference decode written with signed casts, independent of the RTL table
    function automatic logic [63:0] model(input logic [31:0] ins, input logic [2:0] src,
                                          input int xlen);
        logic signed [63:0] v;
        case (src)
            3'd0: v = 64'($signed(ins[31:20]));
            3'd1: v = 64'($signed({ins[31:25], ins[11:7]}));
            3'd2: v = 64'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
            3'd3: v = 64'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
            3'd4: v = 64'($signed({ins[31:12], 12'h000}));
            3'd5: v = {59'd0, ins[19:15]};
            3'd6: v = (xlen == 64) ? {58'd0, ins[25:20]} : {59'd0, ins[24:20]};
            default: v = 64'd0;
        endcase
        if (xlen == 32) v = {32'd0, v[31:0]};
        return v;
    endfunction

    // One clock: sample handshakes at negedge, update scoreboard, return at posedge+1
    task automatic tick(output bit fired, output exp_t e, output exp_t a);
        bit          acc, fire;
        logic [63:0] m;
        @(negedge clk);
        acc   = in_valid && in_ready;
        fire  = out_valid && out_ready;
        fired = 1'b0;
        e     = 'x;
        a     = {out_imm, out_tag, out_err};
        if (!rst_n || flush) begin
            sb.delete();
        end else begin
            if (fire) begin
                fired = 1'b1;
                if (sb.size() > 0) e = sb.pop_front();
            end
            if (acc) begin
                m = model(in_instr, in_immsrc, 32);
                sb.push_back({m[31:0], in_tag, (in_immsrc == 3'b111)});
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        nchk += 7;
        if (out_valid !== 1'b0) begin nerr++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
        if (in_ready !== 1'b1) begin nerr++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
        if (out_imm !== 32'd0) begin nerr++; $display("FAIL rst_out_imm: got %h want 0", out_imm); end
        if (out_tag !== 5'd0) begin nerr++; $display("FAIL rst_out_tag: got %0d want 0", out_tag); end
        if (out_err !== 1'b0) begin nerr++; $display("FAIL rst_out_err: got %b want 0", out_err); end
        if (b_out_valid !== 1'b0) begin nerr++; $display("FAIL rst64_out_valid: got %b want 0", b_out_valid); end
        if (b_in_ready !== 1'b1) begin nerr++; $display("FAIL rst64_in_ready: got %b want 1", b_in_ready); end
        rst_n = 1'b1;
    endtask

    task automatic test_formats();
        bit   f;
        exp_t e, a;
        out_ready = 1'b1;
        // Directed: one per cycle, checking 1-cycle latency and exact value
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1; in_instr = d_instr[i]; in_immsrc = d_src[i]; in_tag = 5'(i + 1);
            tick(f, e, a);
            in_valid = 1'b0;
            nchk += 3;
            if (out_valid !== 1'b1) begin nerr++; $display("FAIL fmt_latency[%0d]: got valid=%b want 1", i, out_valid); end
            if (out_imm !== d_imm[i]) begin nerr++; $display("FAIL fmt_imm[%0d]: got %h want %h", i, out_imm, d_imm[i]); end
            if (out_err !== d_err[i]) begin nerr++; $display("FAIL fmt_err[%0d]: got %b want %b", i, out_err, d_err[i]); end
            tick(f, e, a);
            if (f) begin
                nchk++;
                if (a !== e) begin nerr++; $display("FAIL fmt_sb: got %h/%0d/%b want %h/%0d/%b", a.imm, a.tag, a.err, e.imm, e.tag, e.err); end
            end
        end
        // Random back-to-back, all formats
        for (int i = 0; i < 24; i++) begin
            in_valid = 1'b1; in_instr = $urandom; in_immsrc = 3'($urandom_range(0, 7));
            in_tag = 5'($urandom_range(0, 31));
            tick(f, e, a);
            if (f) begin
                nchk++;
                if (a !== e) begin nerr++; $display("FAIL rnd_sb: got %h/%0d/%b want %h/%0d/%b", a.imm, a.tag, a.err, e.imm, e.tag, e.err); end
            end
        end
        in_valid = 1'b0;
        for (int k = 0; k < 8 && sb.size() > 0; k++) begin
            tick(f, e, a);
            if (f) begin
                nchk++;
                if (a !== e) begin nerr++; $display("FAIL rnd_drain: got %h/%0d/%b want %h/%0d/%b", a.imm, a.tag, a.err, e.imm, e.tag, e.err); end
            end
        end
        nchk++;
        if (sb.size() != 0) begin nerr++; $display("FAIL fmt_drain_timeout: got %0d left want 0", sb.size()); end
    endtask

    task automatic test_back_to_back();
        bit   f, will_acc;
        exp_t e, a, snap;
        int   got[$];
        out_ready = 1'b0; in_immsrc = 3'd0;
        in_valid = 1'b1; in_instr = 32'h00100093; in_tag = 5'd1; tick(f, e, a);
        in_instr = 32'hFFE00093; in_tag = 5'd2; tick(f, e, a);
        nchk++;
        if (in_ready !== 1'b0) begin nerr++; $display("FAIL b2b_in_ready: got %b want 0", in_ready); end
        in_instr = 32'h7FF00093; in_tag = 5'd3;
        snap = {out_imm, out_tag, out_err};
        for (int k = 0; k < 3; k++) begin
            tick(f, e, a);
            nchk += 2;
            if (out_valid !== 1'b1 || out_tag !== 5'd1) begin nerr++; $display("FAIL b2b_hold: got valid=%b tag=%0d want 1/1", out_valid, out_tag); end
            if ({out_imm, out_tag, out_err} !== snap) begin nerr++; $display("FAIL b2b_stable: got %h want %h", {out_imm, out_tag, out_err}, snap); end
        end
        out_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            will_acc = in_valid && in_ready;
            tick(f, e, a);
            if (will_acc) in_valid = 1'b0;
            if (f) begin
                nchk++;
                if (a !== e) begin nerr++; $display("FAIL b2b_sb: got %h/%0d want %h/%0d", a.imm, a.tag, e.imm, e.tag); end
                got.push_back(int'(a.tag));
            end
        end
        in_valid = 1'b0;
        nchk++;
        if (got.size() != 3) begin nerr++; $display("FAIL b2b_count: got %0d want 3", got.size()); end
        else begin
            for (int k = 0; k < 3; k++) begin
                nchk++;
                if (got[k] != k + 1) begin nerr++; $display("FAIL b2b_order[%0d]: got %0d want %0d", k, got[k], k + 1); end
            end
        end
    endtask

    task automatic test_flush();
        bit   f;
        exp_t e, a;
        int   got[$];
        out_ready = 1'b0; in_immsrc = 3'd0; in_instr = 32'h00500093;
        // Both entries full, flush with in_valid high
        in_valid = 1'b1; in_tag = 5'd4; tick(f, e, a);
        in_tag = 5'd5; tick(f, e, a);
        in_tag = 5'd6; flush = 1'b1; tick(f, e, a);
        flush = 1'b0; in_valid = 1'b0;
        nchk += 2;
        if (out_valid !== 1'b0) begin nerr++; $display("FAIL flush_full_valid: got %b want 0", out_valid); end
        if (in_ready !== 1'b1) begin nerr++; $display("FAIL flush_full_ready: got %b want 1", in_ready); end
        // Only M full: the same-cycle handshake must be discarded
        in_valid = 1'b1; in_tag = 5'd8; tick(f, e, a);
        in_tag = 5'd9; flush = 1'b1; tick(f, e, a);
        flush = 1'b0; in_valid = 1'b0;
        nchk += 2;
        if (out_valid !== 1'b0) begin nerr++; $display("FAIL flush_acc_valid: got %b want 0", out_valid); end
        if (in_ready !== 1'b1) begin nerr++; $display("FAIL flush_acc_ready: got %b want 1", in_ready); end
        out_ready = 1'b1; in_valid = 1'b1; in_tag = 5'd10; tick(f, e, a);
        in_valid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick(f, e, a);
            if (f) begin
                nchk++;
                if (a !== e) begin nerr++; $display("FAIL flush_sb: got %h/%0d want %h/%0d", a.imm, a.tag, e.imm, e.tag); end
                got.push_back(int'(a.tag));
            end
        end
        nchk++;
        if (got.size() != 1 || got[0] != 10) begin nerr++; $display("FAIL flush_leak: got %0d entries first=%0d want 1 entry tag 10", got.size(), (got.size() > 0) ? got[0] : -1); end
    endtask

    task automatic test_throughput();
        bit   f;
        exp_t e, a;
        int   fires = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            in_valid = 1'b1; in_instr = $urandom; in_immsrc = 3'($urandom_range(0, 6));
            in_tag = 5'(i);
            tick(f, e, a);
            if (f) begin
                fires++; nchk++;
                if (a !== e) begin nerr++; $display("FAIL tput_sb: got %h/%0d want %h/%0d", a.imm, a.tag, e.imm, e.tag); end
            end
        end
        nchk++;
        if (fires != 19) begin nerr++; $display("FAIL tput_rate: got %0d fires want 19", fires); end
        in_valid = 1'b0;
        tick(f, e, a);
        if (f) begin
            fires++; nchk++;
            if (a !== e) begin nerr++; $display("FAIL tput_last: got %h/%0d want %h/%0d", a.imm, a.tag, e.imm, e.tag); end
        end
        nchk++;
        if (fires != 20) begin nerr++; $display("FAIL tput_total: got %0d want 20", fires); end
    endtask

    task automatic test_reset_mid();
        bit   f;
        exp_t e, a;
        out_ready = 1'b0; in_immsrc = 3'd4; in_instr = 32'hABCDE037;
        in_valid = 1'b1; in_tag = 5'd11; tick(f, e, a);
        in_tag = 5'd12; tick(f, e, a);
        in_valid = 1'b0;
        nchk++;
        if (in_ready !== 1'b0) begin nerr++; $display("FAIL rmid_full: got in_ready=%b want 0", in_ready); end
        rst_n = 1'b0; tick(f, e, a);
        rst_n = 1'b1;
        nchk += 3;
        if (out_valid !== 1'b0) begin nerr++; $display("FAIL rmid_valid: got %b want 0", out_valid); end
        if (in_ready !== 1'b1) begin nerr++; $display("FAIL rmid_ready: got %b want 1", in_ready); end
        if (out_imm !== 32'd0) begin nerr++; $display("FAIL rmid_imm: got %h want 0", out_imm); end
    endtask

    task automatic test_x64();
        logic [31:0] vi [4] = '{32'h800000B7, 32'h03F0D093, 32'hFFF00093, 32'h12345037};
        logic [2:0]  vs [4] = '{3'd4, 3'd6, 3'd0, 3'd4};
        logic [63:0] vx [4] = '{64'hFFFFFFFF80000000, 64'h000000000000003F,
                                64'hFFFFFFFFFFFFFFFF, 64'h0000000012345000};
        b_out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            b_in_valid = 1'b1; b_in_instr = vi[i]; b_in_immsrc = vs[i]; b_in_tag = 5'(i);
            @(posedge clk); #1;
            b_in_valid = 1'b0;
            nchk += 3;
            if (b_out_valid !== 1'b1) begin nerr++; $display("FAIL x64_valid[%0d]: got %b want 1", i, b_out_valid); end
            if (b_out_imm !== vx[i]) begin nerr++; $display("FAIL x64_imm[%0d]: got %h want %h", i, b_out_imm, vx[i]); end
            if (b_out_tag !== 5'(i)) begin nerr++; $display("FAIL x64_tag[%0d]: got %0d want %0d", i, b_out_tag, i); end
        end
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_instr = 32'd0;
        in_immsrc = 3'd0; in_tag = 5'd0; out_ready = 1'b0;
        b_in_valid = 1'b0; b_in_instr = 32'd0; b_in_immsrc = 3'd0;
        b_in_tag = 5'd0; b_out_ready = 1'b0;
        test_reset();
        test_formats();
        test_back_to_back();
        test_flush();
        test_throughput();
        test_reset_mid();
        test_x64();
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
